// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage core. It also forwards the MEM-stage
// result, detects load-use hazards, tracks illegal control and counts instructions.
module ex_mem_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_result,
  input  logic [DW-1:0] ex_write_data,
  input  logic [4:0]    ex_write_reg,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic [4:0]    ex_rs,
  input  logic [4:0]    ex_rt,
  output logic          mem_valid,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_mem_to_reg,
  output logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] mem_write_data,
  output logic [4:0]    mem_write_reg,
  output logic          fwd_rs_hit,
  output logic          fwd_rt_hit,
  output logic          load_use_hazard,
  output logic          ctrl_err,
  output logic [15:0]   inst_count
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic [4:0]    write_reg;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] write_data;
  } stage_t;

  stage_t q, d;
  logic   illegal, take;

  // A read+write instruction cannot be performed; it is dropped as a bubble.
  assign illegal = ex_valid & ex_mem_read & ex_mem_write;
  assign take    = ex_valid & ~illegal;

  always_comb begin
    d = '0;
    if (take) begin
      d.valid      = 1'b1;
      // $0 is hard-wired zero, so a write to it is suppressed here, which
      // also keeps every hazard compare below from matching register 0.
      d.reg_write  = ex_reg_write & (ex_write_reg != 5'd0);
      d.mem_read   = ex_mem_read;
      d.mem_write  = ex_mem_write;
      d.mem_to_reg = ex_mem_to_reg;
      d.write_reg  = ex_write_reg;
      d.alu_result = ex_alu_result;
      d.write_data = ex_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      ctrl_err   <= 1'b0;
      inst_count <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
      if (take)    inst_count <= inst_count + 16'd1;
      if (illegal) ctrl_err   <= 1'b1;
    end
  end

  assign mem_valid      = q.valid;
  assign mem_reg_write  = q.reg_write;
  assign mem_mem_read   = q.mem_read;
  assign mem_mem_write  = q.mem_write;
  assign mem_mem_to_reg = q.mem_to_reg;
  assign mem_write_reg  = q.write_reg;
  assign mem_alu_result = q.alu_result;
  assign mem_write_data = q.write_data;

  // Only ALU results can be forwarded from MEM; load data arrives a stage later.
  assign fwd_rs_hit = q.valid & q.reg_write & ~q.mem_to_reg & (q.write_reg == ex_rs);
  assign fwd_rt_hit = q.valid & q.reg_write & ~q.mem_to_reg & (q.write_reg == ex_rt);
  assign load_use_hazard = q.valid & q.mem_read & q.reg_write &
                           ((q.write_reg == ex_rs) | (q.write_reg == ex_rt));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: load, $0 suppression, hazards, stall/flush,
// illegal-control bubble, reset priority and counter wrap.
module tb_ex_mem_reg;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, stall, flush, ex_valid;
  logic [DW-1:0] ex_alu_result, ex_write_data;
  logic [4:0]    ex_write_reg, ex_rs, ex_rt;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [DW-1:0] mem_alu_result, mem_write_data;
  logic [4:0]    mem_write_reg;
  logic          fwd_rs_hit, fwd_rt_hit, load_use_hazard, ctrl_err;
  logic [15:0]   inst_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_write_reg(mem_write_reg),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .load_use_hazard(load_use_hazard), .ctrl_err(ctrl_err),
    .inst_count(inst_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                       input logic [4:0] wr, input logic rw, input logic mr,
                       input logic mw, input logic m2r);
    ex_valid = v; ex_alu_result = alu; ex_write_data = wd; ex_write_reg = wr;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_rs = '0; ex_rt = '0;
    drive(1'b1, 32'hdead_beef, 32'h1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst_valid", mem_valid, 0);
    chk("rst_alu", mem_alu_result, 0);
    chk("rst_cnt", inst_count, 0);
    chk("rst_err", ctrl_err, 0);
    chk("rst_fwd", {fwd_rs_hit, fwd_rt_hit, load_use_hazard}, 0);

    // basic load and forward
    rst = 1'b0;
    drive(1'b1, 32'h0000_1234, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld_alu", mem_alu_result, 32'h1234);
    chk("ld_wreg", mem_write_reg, 8);
    chk("ld_rw", mem_reg_write, 1);
    chk("ld_cnt", inst_count, 1);
    ex_rs = 5'd8; #1;
    chk("ld_fwd_rs", fwd_rs_hit, 1);
    chk("ld_fwd_rt", fwd_rt_hit, 0);

    // stall holds for 3 cycles even with new EX inputs
    stall = 1'b1;
    drive(1'b1, 32'h9999, 32'h7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    chk("st_alu", mem_alu_result, 32'h1234);
    chk("st_wreg", mem_write_reg, 8);
    chk("st_cnt", inst_count, 1);
    chk("st_fwd", fwd_rs_hit, 1);

    // stall+flush: flush wins
    flush = 1'b1;
    step();
    chk("fl_valid", mem_valid, 0);
    chk("fl_data", {mem_alu_result, mem_write_reg, mem_reg_write}, 0);
    chk("fl_fwd", {fwd_rs_hit, fwd_rt_hit, load_use_hazard}, 0);
    chk("fl_cnt", inst_count, 1);

    // $0 destination suppresses reg_write
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    ex_rs = 5'd0; #1;
    chk("r0_valid", mem_valid, 1);
    chk("r0_rw", mem_reg_write, 0);
    chk("r0_fwd", fwd_rs_hit, 0);
    chk("r0_cnt", inst_count, 2);

    // lw then dependent use
    drive(1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    ex_rs = 5'd1; ex_rt = 5'd5; #1;
    chk("lu_haz", load_use_hazard, 1);
    chk("lu_fwd_rt", fwd_rt_hit, 0);
    chk("lu_cnt", inst_count, 3);
    ex_rt = 5'd6; #1;
    chk("lu_nohaz", load_use_hazard, 0);

    // ex_valid=0 captures a bubble
    drive(1'b0, 32'h77, 32'h77, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("bub_valid", mem_valid, 0);
    chk("bub_data", {mem_alu_result, mem_write_data}, 0);
    chk("bub_cnt", inst_count, 3);

    // illegal read+write -> bubble and sticky error
    drive(1'b1, 32'h88, 32'h88, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("ill_valid", mem_valid, 0);
    chk("ill_ctl", {mem_mem_read, mem_mem_write, mem_reg_write}, 0);
    chk("ill_err", ctrl_err, 1);
    chk("ill_cnt", inst_count, 3);
    drive(1'b1, 32'h44, 32'hcafe, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("sw_wd", mem_write_data, 32'hcafe);
    chk("sw_mw", mem_mem_write, 1);
    chk("err_sticky", ctrl_err, 1);
    chk("sw_cnt", inst_count, 4);

    // reset mid-stall discards held contents
    stall = 1'b1; flush = 1'b1; rst = 1'b1;
    step();
    ex_rs = 5'd0; ex_rt = 5'd0; #1;
    chk("rs_valid", mem_valid, 0);
    chk("rs_data", {mem_write_data, mem_alu_result}, 0);
    chk("rs_err", ctrl_err, 0);
    chk("rs_cnt", inst_count, 0);
    chk("rs_fwd", {fwd_rs_hit, fwd_rt_hit, load_use_hazard}, 0);

    // counter wrap
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h1, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (65535) step();
    chk("wr_max", inst_count, 16'hffff);
    step();
    chk("wr_zero", inst_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the width of the ALU result and store-data paths.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port stall, input, 1 bit: hold all registered contents.
REQ-005 SHALL have port flush, input, 1 bit: load a bubble.
REQ-006 SHALL have port ex_valid, input, 1 bit: the EX-stage instruction is real (not a bubble).
REQ-007 SHALL have ports ex_alu_result and ex_write_data, input, DW bits each: the ALU result and the rt value for stores.
REQ-008 SHALL have port ex_write_reg, input, 5 bits: destination register from the EX RegDst selection.
REQ-009 SHALL have ports ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg, input, 1 bit each: EX control bits.
REQ-010 SHALL have ports ex_rs and ex_rt, input, 5 bits each: source registers of the instruction now in EX, used for hazard compare.
REQ-011 SHALL have ports mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and mem_mem_to_reg, output, 1 bit each: registered MEM-stage state.
REQ-012 SHALL have ports mem_alu_result and mem_write_data (output, DW bits each) and mem_write_reg (output, 5 bits): registered MEM-stage data.
REQ-013 SHALL have ports fwd_rs_hit and fwd_rt_hit, output, 1 bit each: the MEM-stage ALU result can be forwarded to rs or rt.
REQ-014 SHALL have port load_use_hazard, output, 1 bit: the instruction in EX needs a load result that is not yet available.
REQ-015 SHALL have port ctrl_err, output, 1 bit: sticky flag for an illegal control combination.
REQ-016 SHALL have port inst_count, output, 16 bits: count of valid instructions captured.

Function
REQ-017 SHALL evaluate one action per rising clk edge, in priority order rst > flush > stall > load.
REQ-018 Load (no rst, flush or stall) SHALL register all ex_* inputs into the mem_* outputs, giving 1-cycle latency.
REQ-019 Bubble (flush, or the illegal case in REQ-022) SHALL set mem_valid and all mem control bits to 0 and all mem data outputs to 0.
REQ-020 Stall without flush SHALL hold every registered output, including inst_count.
REQ-021 On load, mem_reg_write SHALL equal ex_reg_write AND ex_valid AND (ex_write_reg != 0), so register $0 is never written.
REQ-022 On load with ex_valid=1 and ex_mem_read=ex_mem_write=1, SHALL capture a bubble and set ctrl_err=1.
REQ-023 ctrl_err SHALL stay set until rst.
REQ-024 On load with ex_valid=0, SHALL capture a bubble (same result as REQ-019).
REQ-025 inst_count SHALL increment by 1 only when a valid, non-bubble instruction is captured.
REQ-026 inst_count SHALL wrap from 0xFFFF to 0x0000.
REQ-027 fwd_rs_hit (combinational) SHALL be mem_valid & mem_reg_write & !mem_mem_to_reg & (mem_write_reg == ex_rs); fwd_rt_hit SHALL be the same with ex_rt.
REQ-028 load_use_hazard (combinational) SHALL be mem_valid & mem_mem_read & mem_reg_write & ((mem_write_reg == ex_rs) | (mem_write_reg == ex_rt)).
REQ-029 fwd_*_hit and load_use_hazard SHALL never assert for register 0; this follows from REQ-021.
REQ-030 fwd_*_hit and load_use_hazard SHALL follow the held contents during stall and SHALL be 0 after a flush.
REQ-031 flush and stall in the same cycle SHALL give a bubble (flush wins).

Reset
REQ-032 rst=1 at a clock edge SHALL zero all registered outputs: mem_*, ctrl_err and inst_count.
REQ-033 Reset SHALL override stall and flush.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction.
REQ-035 After reset, fwd_rs_hit, fwd_rt_hit and load_use_hazard SHALL be 0 regardless of ex_rs and ex_rt.

Verification
REQ-036 Load: ex_valid=1, alu=0x0000_1234, wreg=8, reg_write=1 -> next cycle mem_alu_result=0x1234, mem_write_reg=8, mem_reg_write=1, inst_count=1; with ex_rs=8, fwd_rs_hit=1.
REQ-037 $0 suppression: wreg=0, reg_write=1 -> mem_reg_write=0; fwd_rs_hit=0 with ex_rs=0.
REQ-038 Load-use: capture lw (mem_read=1, mem_to_reg=1, wreg=5), then ex_rt=5 -> load_use_hazard=1 and fwd_rt_hit=0.
REQ-039 Stall/flush: stall=1 for 3 cycles -> outputs and inst_count unchanged; stall=1 with flush=1 -> mem_valid=0, outputs 0.
REQ-040 Error and wrap: mem_read=mem_write=1 -> bubble, ctrl_err=1 persists until rst; 65536 valid loads from reset -> inst_count=0x0000.
